conv_window_reg: RTL and testbench



---
 rtl/conv_window_reg.sv | 123 ++++++++++++
 tb/tb_conv_window_reg.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_reg.sv
// Sliding-window tap register: N-bit samples shift into a K-deep chain over a
// valid/ready stream; the whole window is emitted every S samples once the chain is full.
module conv_window_reg #(
  parameter int N = 32,
  parameter int K = 3,
  parameter int S = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic [N-1:0]   in_data,
  input  logic           in_valid,
  input  logic           in_last,
  output logic           in_ready,
  output logic [K*N-1:0] win_data,
  output logic           out_valid,
  output logic           out_last,
  input  logic           out_ready
);

  localparam int FILL_W = ($clog2(K + 1) > 1) ? $clog2(K + 1) : 1;
  localparam int PH_W   = ($clog2(S) > 1) ? $clog2(S) : 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(K);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(S - 1);

  logic [N-1:0]      r_taps [K];
  logic [FILL_W-1:0] r_fill;
  logic [PH_W-1:0]   r_ph;
  logic              r_out_valid;
  logic              r_out_last;

  logic              w_in_ready;
  logic              w_accept;
  logic [FILL_W-1:0] w_fill_next;
  logic              w_full_next;
  logic              w_produce;
  logic [PH_W-1:0]   w_ph_next;

  function automatic logic [FILL_W-1:0] sat_inc(input logic [FILL_W-1:0] f);
    return (f == FILL_FULL) ? f : f + 1'b1;
  endfunction

  function automatic logic [PH_W-1:0] ph_wrap_inc(input logic [PH_W-1:0] p);
    return (p == PH_LAST) ? '0 : p + 1'b1;
  endfunction

  // A pending window that is not being consumed blocks the input side.
  assign w_in_ready  = !r_out_valid || out_ready;
  assign w_accept    = in_valid && w_in_ready && !clear;
  assign w_fill_next = sat_inc(r_fill);
  assign w_full_next = w_accept && (w_fill_next == FILL_FULL);
  assign w_produce   = w_full_next && (r_ph == '0);
  assign w_ph_next   = ph_wrap_inc(r_ph);

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

  always_comb begin
    win_data = '0;
    for (int i = 0; i < K; i++) begin
      win_data[i*N +: N] = r_taps[i];
    end
  end

  // Stage p0: tap chain, shifts only on an accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) r_taps[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < K; i++) r_taps[i] <= '0;
    end else if (w_accept) begin
      for (int i = K - 1; i > 0; i--) r_taps[i] <= r_taps[i-1];
      r_taps[0] <= in_data;
    end
  end

  // Stage p0: fill / stride phase; a last sample restarts both for the next sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill <= '0;
      r_ph   <= '0;
    end else if (clear) begin
      r_fill <= '0;
      r_ph   <= '0;
    end else if (w_accept) begin
      if (in_last) begin
        r_fill <= '0;
        r_ph   <= '0;
      end else begin
        r_fill <= w_fill_next;
        r_ph   <= w_full_next ? w_ph_next : '0;
      end
    end
  end

  // Stage p1: output handshake state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (clear) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_produce) begin
      r_out_valid <= 1'b1;
      r_out_last  <= in_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  a_hold_window: assert property (@(posedge clk) disable iff (!rst_n)
    (r_out_valid && !out_ready && !clear) |=>
      (r_out_valid && $stable(win_data) && $stable(r_out_last)));

  a_fill_range: assert property (@(posedge clk) disable iff (!rst_n)
    r_fill <= FILL_FULL);
`endif

endmodule

// File: tb/tb_conv_window_reg.sv
// Bench for conv_window_reg: two instances (S=1 and S=2) share one input stream and are
// compared each cycle against a sample-count based reference model.
module tb_conv_window_reg;

  localparam int N = 8;
  localparam int K = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic [N-1:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;

  logic [1:0] rdy, ov, ol;
  logic [K*N-1:0] wd0, wd1;

  int n_cmp = 0;
  int n_bad = 0;

  // model state, index 0 = S=1 instance, index 1 = S=2 instance
  logic [N-1:0] m_taps [2][K];
  int           m_cnt  [2];
  logic         m_ov   [2];
  logic         m_ol   [2];

  always #5 clk = ~clk;

  conv_window_reg #(.N(N), .K(K), .S(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rdy[0]), .win_data(wd0), .out_valid(ov[0]),
    .out_last(ol[0]), .out_ready(out_ready));

  conv_window_reg #(.N(N), .K(K), .S(2)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rdy[1]), .win_data(wd1), .out_valid(ov[1]),
    .out_last(ol[1]), .out_ready(out_ready));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int stride_of(input int j);
    return (j == 0) ? 1 : 2;
  endfunction

  function automatic logic [K*N-1:0] model_win(input int j);
    return {m_taps[j][2], m_taps[j][1], m_taps[j][0]};
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < K; i++) m_taps[j][i] = '0;
      m_cnt[j] = 0;
      m_ov[j]  = 1'b0;
      m_ol[j]  = 1'b0;
    end
  endtask

  // A window is due when the sample count of the current sequence reaches K
  // and then every S samples after that.
  task automatic model_step(input int j, input logic v, input logic [N-1:0] d,
                            input logic l, input logic clr, input logic ordy);
    logic acc, prod;
    if (clr) begin
      for (int i = 0; i < K; i++) m_taps[j][i] = '0;
      m_cnt[j] = 0;
      m_ov[j]  = 1'b0;
      m_ol[j]  = 1'b0;
      return;
    end
    acc  = v && (!m_ov[j] || ordy);
    prod = 1'b0;
    if (acc) begin
      for (int i = K - 1; i > 0; i--) m_taps[j][i] = m_taps[j][i-1];
      m_taps[j][0] = d;
      m_cnt[j]++;
      if (m_cnt[j] >= K && ((m_cnt[j] - K) % stride_of(j)) == 0) prod = 1'b1;
      if (l) m_cnt[j] = 0;
    end
    if (prod) begin
      m_ov[j] = 1'b1;
      m_ol[j] = l;
    end else if (ordy) begin
      m_ov[j] = 1'b0;
      m_ol[j] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check_eq("s1_out_valid", 64'(ov[0]), 64'(m_ov[0]));
    check_eq("s1_out_last",  64'(ol[0]), 64'(m_ol[0]));
    check_eq("s1_win_data",  64'(wd0),   64'(model_win(0)));
    check_eq("s2_out_valid", 64'(ov[1]), 64'(m_ov[1]));
    check_eq("s2_out_last",  64'(ol[1]), 64'(m_ol[1]));
    check_eq("s2_win_data",  64'(wd1),   64'(model_win(1)));
  endtask

  // Called at a falling edge: drive, check in_ready, clock once, check outputs.
  task automatic step(input logic v, input logic [N-1:0] d, input logic l,
                      input logic clr, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    clear     = clr;
    out_ready = ordy;
    #1;
    check_eq("s1_in_ready", 64'(rdy[0]), 64'(!m_ov[0] || ordy));
    check_eq("s2_in_ready", 64'(rdy[1]), 64'(!m_ov[1] || ordy));
    for (int j = 0; j < 2; j++) model_step(j, v, d, l, clr, ordy);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; clear = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs();
  endtask

  logic [K*N-1:0] held;

  initial begin
    model_reset();
    @(negedge clk);
    check_eq("reset_win_data", 64'(wd0), 64'(0));
    check_eq("reset_out_valid", 64'(ov), 64'(0));
    check_eq("reset_in_ready", 64'(rdy), 64'(2'b11));
    do_reset();

    // Fill and first window
    step(1, 8'h11, 0, 0, 1);
    step(1, 8'h22, 0, 0, 1);
    check_eq("fill_no_window", 64'(ov[0]), 64'(0));
    step(1, 8'h33, 0, 0, 1);
    check_eq("first_valid", 64'(ov[0]), 64'(1));
    check_eq("first_window", 64'(wd0), 64'(24'h112233));
    step(1, 8'h44, 0, 0, 1);
    check_eq("second_window", 64'(wd0), 64'(24'h223344));

    // Stride: samples 1..9 continuous
    do_reset();
    for (int s = 1; s <= 9; s++) begin
      step(1, N'(s), 0, 0, 1);
      check_eq("stride_emit", 64'(ov[1]), 64'((s >= 3) && (s % 2 == 1)));
      if (s == 7) check_eq("stride_win7", 64'(wd1), 64'(24'h050607));
    end

    // Back-pressure
    do_reset();
    step(1, 8'h01, 0, 0, 0);
    step(1, 8'h02, 0, 0, 0);
    step(1, 8'h03, 0, 0, 0);
    held = wd0;
    for (int c = 0; c < 5; c++) begin
      step(1, 8'h04, 0, 0, 0);
      check_eq("bp_held", 64'(wd0), 64'(held));
    end
    check_eq("bp_held_value", 64'(held), 64'(24'h010203));
    step(1, 8'h04, 0, 0, 1);
    check_eq("bp_release_accept", 64'(wd0), 64'(24'h020304));

    // Sequence end
    do_reset();
    step(1, 8'h01, 0, 0, 1);
    step(1, 8'h02, 0, 0, 1);
    step(1, 8'h03, 1, 0, 1);
    check_eq("last_valid", 64'(ov[0]), 64'(1));
    check_eq("last_flag", 64'(ol[0]), 64'(1));
    step(1, 8'h04, 0, 0, 1);
    step(1, 8'h05, 0, 0, 1);
    check_eq("last_refill_none", 64'(ov[0]), 64'(0));
    step(1, 8'h06, 0, 0, 1);
    check_eq("last_next_window", 64'(wd0), 64'(24'h040506));
    check_eq("last_next_flag", 64'(ol[0]), 64'(0));

    // Clear
    do_reset();
    step(1, 8'h01, 0, 0, 1);
    step(1, 8'h02, 0, 0, 1);
    step(1, 8'hAA, 0, 1, 1);
    check_eq("clear_taps", 64'(wd0), 64'(0));
    step(1, 8'h07, 0, 0, 1);
    step(1, 8'h08, 0, 0, 1);
    check_eq("clear_refill", 64'(ov[0]), 64'(0));
    step(1, 8'h09, 0, 0, 1);
    check_eq("clear_window", 64'(wd0), 64'(24'h070809));

    // Async reset while a window is pending
    step(0, 8'h00, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_out_valid", 64'(ov), 64'(0));
    check_eq("async_win_data", 64'(wd0), 64'(0));
    do_reset();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 3) != 0, N'($urandom), $urandom_range(0, 11) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
